// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks (the TX controller today and the RX
// controller later).
//
// Contents
//   uartState_t  frame sequencing states
//   PAR_*        parity mode selectors used by the PARITY parameter
//   calcParity   parity bit for a data word under a given parity mode
// ---------------------------------------------------------------------------
package uart_pkg;

  // Frame sequencing states. IDLE is the all-zero encoding so a freshly
  // reset register and the "not busy" condition line up naturally.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uartState_t;

  // Parity mode selectors.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Widest data word any UART block supports.
  localparam int MAX_DATA_BITS = 9;

  // Parity bit for a data word. Callers zero-extend narrower words, which
  // leaves the XOR reduction unchanged. Even parity makes the total number
  // of ones (data plus parity) even; odd parity makes it odd.
  function automatic logic calcParity(input logic [MAX_DATA_BITS-1:0] data,
                                      input int mode);
    logic ones;
    ones = ^data;
    return (mode == PAR_ODD) ? ~ones : ones;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Divides the oversampled baud enable down to bit periods. The counter
// advances on every i_tick while i_clear is low and flags the tick that
// completes a bit period, then wraps to zero for the next bit.
//
// Ports
//   i_clk      clock
//   i_rst      synchronous active-high reset
//   i_tick     oversample enable, one i_clk cycle wide
//   i_clear    holds the counter at zero and suppresses o_bitEnd
//   o_bitEnd   high on the tick that ends the current bit period
// ---------------------------------------------------------------------------
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_clear,
  output logic o_bitEnd
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

  logic [TW-1:0] r_tcnt;
  logic          w_atLast;

  assign w_atLast = (r_tcnt == LAST_TICK);

  // A bit ends on the tick that finds the counter at its last value.
  // Clearing masks the flag so a tick arriving while the owner is idle
  // never looks like a bit boundary.
  assign o_bitEnd = i_tick & ~i_clear & w_atLast;

  // Tick counter. The explicit wrap keeps non power-of-two oversample
  // ratios exact instead of relying on natural rollover.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tcnt <= '0;
    end else if (i_clear) begin
      r_tcnt <= '0;
    end else if (i_tick) begin
      if (w_atLast) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmit controller. Takes one data word per ready/valid handshake
// and serialises it as: start bit (0), DATA_BITS data bits LSB first, an
// optional parity bit, then STOP_BITS stop bits (1). Each bit lasts
// OVERSAMPLE pulses of i_tick.
//
// Parameters
//   DATA_BITS   data bits per frame (5..9)
//   PARITY      PAR_NONE, PAR_EVEN or PAR_ODD
//   STOP_BITS   1 or 2
//   OVERSAMPLE  i_tick pulses per bit period (>= 2)
//
// Ports
//   i_clk     clock
//   i_rst     synchronous active-high reset
//   i_tick    baud x OVERSAMPLE enable, one cycle wide
//   i_data    word to send, captured only on accept
//   i_valid   source has a word
//   o_ready   controller can accept a word (IDLE only)
//   o_tx      serial line, idle high, straight from a flop
//   o_busy    a frame is in progress
//   o_done    one-cycle pulse after the last stop bit completes
// ---------------------------------------------------------------------------
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tick,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  uartState_t           r_state;
  uartState_t           w_stateNext;
  logic [DATA_BITS-1:0] r_shiftReg;
  logic [DATA_BITS-1:0] w_shiftNext;
  logic [CW-1:0]        r_bitCnt;
  logic [CW-1:0]        w_bitCntNext;
  logic                 r_parityBit;
  logic                 w_parityNext;
  logic                 r_tx;
  logic                 w_txNext;
  logic                 r_done;
  logic                 w_doneNext;
  logic                 w_bitEnd;
  logic                 w_idle;

  assign w_idle  = (r_state == ST_IDLE);
  assign o_ready = w_idle;
  assign o_busy  = ~w_idle;
  assign o_tx    = r_tx;
  assign o_done  = r_done;

  // The timer is held clear while idle, so a tick landing in the accept
  // cycle is not counted and the start bit gets its full length.
  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bitTimer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_tick   (i_tick),
    .i_clear  (w_idle),
    .o_bitEnd (w_bitEnd)
  );

  // Next-state and datapath logic. Every register's next value defaults to
  // "hold" and only the current state's bit-end handling changes it. The
  // bit counter is shared: it counts data bits in DATA and stop bits in
  // STOP, and is zeroed whenever it moves between the two uses.
  always_comb begin
    w_stateNext  = r_state;
    w_shiftNext  = r_shiftReg;
    w_bitCntNext = r_bitCnt;
    w_parityNext = r_parityBit;
    w_doneNext   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_bitCntNext = '0;
        if (i_valid) begin
          w_shiftNext  = i_data;
          w_parityNext = calcParity(MAX_DATA_BITS'(i_data), PARITY);
          w_stateNext  = ST_START;
        end
      end

      ST_START: begin
        if (w_bitEnd) begin
          w_stateNext = ST_DATA;
        end
      end

      ST_DATA: begin
        if (w_bitEnd) begin
          w_shiftNext = {1'b0, r_shiftReg[DATA_BITS-1:1]};
          if (r_bitCnt == LAST_DATA) begin
            w_bitCntNext = '0;
            w_stateNext  = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            w_bitCntNext = r_bitCnt + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (w_bitEnd) begin
          w_stateNext = ST_STOP;
        end
      end

      ST_STOP: begin
        if (w_bitEnd) begin
          if (r_bitCnt == LAST_STOP) begin
            w_bitCntNext = '0;
            w_stateNext  = ST_IDLE;
            w_doneNext   = 1'b1;
          end else begin
            w_bitCntNext = r_bitCnt + 1'b1;
          end
        end
      end

      default: begin
        w_stateNext  = ST_IDLE;
        w_bitCntNext = '0;
      end
    endcase
  end

  // The line level is decided from the state being entered, so the flop
  // shows the new bit in the same cycle the state register changes and
  // o_tx never passes through combinational logic on its way out.
  always_comb begin
    w_txNext = 1'b1;
    case (w_stateNext)
      ST_START:  w_txNext = 1'b0;
      ST_DATA:   w_txNext = w_shiftNext[0];
      ST_PARITY: w_txNext = w_parityNext;
      default:   w_txNext = 1'b1;
    endcase
  end

  // All controller state. Reset abandons any frame in flight: the line
  // returns high and no completion pulse is produced.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_shiftReg  <= '0;
      r_bitCnt    <= '0;
      r_parityBit <= 1'b0;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_shiftReg  <= w_shiftNext;
      r_bitCnt    <= w_bitCntNext;
      r_parityBit <= w_parityNext;
      r_tx        <= w_txNext;
      r_done      <= w_doneNext;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Four controller instances cover 8N1, 8E1, 8O1 and 8N2. One instance is
// selected at a time; only it sees i_valid and only its outputs are checked.
// A frame-level model predicts the line every cycle: on accept it builds the
// list of frame bits, then counts ticks and indexes that list by
// ticks / OVERSAMPLE until the whole frame has been counted.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       valid;
  logic [7:0] data;
  logic [1:0] sel;
  logic [3:0] validVec;
  logic [3:0] txVec;
  logic [3:0] busyVec;
  logic [3:0] readyVec;
  logic [3:0] doneVec;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tickMode = 0;

  int cfgParity [4] = '{0, 1, 2, 0};
  int cfgStop   [4] = '{1, 1, 1, 2};

  // Frame model state
  bit mBits[$];
  bit mBusy = 1'b0;
  int mCnt  = 0;
  int mTotal = 0;
  bit expDone = 1'b0;

  // Directed per-bit level probes
  int probeLv [12];
  int probeCnt = 0;

  always #5 clk = ~clk;

  assign validVec = valid ? (4'b0001 << sel) : 4'b0000;

  uart_tx_ctrl #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_data(data), .i_valid(validVec[0]),
    .o_ready(readyVec[0]), .o_tx(txVec[0]), .o_busy(busyVec[0]), .o_done(doneVec[0]));

  uart_tx_ctrl #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(OS)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_data(data), .i_valid(validVec[1]),
    .o_ready(readyVec[1]), .o_tx(txVec[1]), .o_busy(busyVec[1]), .o_done(doneVec[1]));

  uart_tx_ctrl #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(OS)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_data(data), .i_valid(validVec[2]),
    .o_ready(readyVec[2]), .o_tx(txVec[2]), .o_busy(busyVec[2]), .o_done(doneVec[2]));

  uart_tx_ctrl #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(OS)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_data(data), .i_valid(validVec[3]),
    .o_ready(readyVec[3]), .o_tx(txVec[3]), .o_busy(busyVec[3]), .o_done(doneVec[3]));

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame as a bit list: start, data LSB first, optional parity, stop bits.
  function automatic void buildFrame(input logic [7:0] d, input int cfg);
    int ones;
    mBits.delete();
    mBits.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      mBits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (cfgParity[cfg] == 1) mBits.push_back((ones % 2) == 1);
    if (cfgParity[cfg] == 2) mBits.push_back((ones % 2) == 0);
    for (int i = 0; i < cfgStop[cfg]; i++) mBits.push_back(1'b1);
    mTotal = mBits.size() * OS;
  endfunction

  // One clock cycle: drive inputs, advance the model at the edge, then
  // compare the selected instance's outputs on the falling edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    bit expTx;
    valid = v;
    data  = d;
    rst   = r;
    case (tickMode)
      0:       tick = 1'b1;
      1:       tick = ((cyc % 4) == 0);
      default: tick = ($urandom_range(0, 1) == 1);
    endcase
    @(posedge clk);
    expDone = 1'b0;
    if (r) begin
      mBusy = 1'b0;
    end else if (mBusy) begin
      if (tick) begin
        mCnt++;
        if (mCnt == mTotal) begin
          mBusy   = 1'b0;
          expDone = 1'b1;
        end
      end
    end else if (v) begin
      buildFrame(d, int'(sel));
      mBusy = 1'b1;
      mCnt  = 0;
    end
    cyc++;
    @(negedge clk);
    expTx = mBusy ? mBits[mCnt / OS] : 1'b1;
    checkOutput("tx",    32'(txVec[sel]),    32'(expTx));
    checkOutput("busy",  32'(busyVec[sel]),  32'(mBusy));
    checkOutput("ready", 32'(readyVec[sel]), 32'(!mBusy));
    checkOutput("done",  32'(doneVec[sel]),  32'(expDone));
  endtask

  // Sends one word and measures cycles to o_done. Optionally probes each
  // bit's level at mid-bit, the length of the final high run, and pulses
  // i_valid with 0x3C at one chosen cycle while busy.
  task automatic runFrame(input string tag, input logic [7:0] d, input int expLat,
                          input int bitLen, input int expStopRun, input int pulseAt);
    int  n;
    int  run;
    bit  seen;
    bit  pv;
    applyStimulus(1'b1, d, 1'b0);
    n = 0; run = 0; seen = 1'b0;
    while (n < 3000 && !seen) begin
      n++;
      pv = (n == pulseAt);
      applyStimulus(pv, pv ? 8'h3C : 8'($urandom), 1'b0);
      if (doneVec[sel]) begin
        seen = 1'b1;
      end else begin
        if (txVec[sel]) run++; else run = 0;
        for (int b = 0; b < probeCnt; b++)
          if (n == bitLen * b + bitLen / 2)
            checkOutput($sformatf("%s_bit%0d", tag, b), 32'(txVec[sel]), 32'(probeLv[b]));
      end
    end
    checkOutput({tag, "_latency"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(expLat));
    if (expStopRun > 0) checkOutput({tag, "_stoprun"}, 32'(run), 32'(expStopRun));
  endtask

  task automatic doReset(input logic [1:0] s);
    sel = s;
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
  endtask

  initial begin : main
    int n;
    int dones;
    int firstDone;
    int secondDone;
    bit v;
    valid = 1'b0; data = 8'h00; rst = 1'b1; tick = 1'b0; sel = 2'd0;

    // 8N1, 0xA5, tick every cycle
    tickMode = 0;
    doReset(2'd0);
    probeLv[0:9] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    probeCnt = 10;
    runFrame("t1", 8'hA5, 160, 16, 0, -1);

    // Even and odd parity, 0xA5
    doReset(2'd1);
    probeLv[0:10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    probeCnt = 11;
    runFrame("t2e", 8'hA5, 176, 16, 0, -1);
    doReset(2'd2);
    probeLv[9] = 1;
    runFrame("t2o", 8'hA5, 176, 16, 0, -1);
    probeCnt = 0;

    // Back-to-back: 0x00 then 0xFF, valid held high
    doReset(2'd0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    n = 0; dones = 0; firstDone = -1; secondDone = -1;
    while (n < 1000 && dones < 2) begin
      n++;
      v = (dones == 0) || (n == firstDone + 1);
      applyStimulus(v, 8'hFF, 1'b0);
      if (doneVec[sel]) begin
        dones++;
        if (dones == 1) firstDone = n; else secondDone = n;
      end
    end
    checkOutput("t3_firstDone",  32'(firstDone),  32'd160);
    checkOutput("t3_secondDone", 32'(secondDone), 32'd321);

    // Valid pulse while busy is ignored
    doReset(2'd0);
    runFrame("t4", 8'h55, 160, 16, 0, 40);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h3C, 1'b0);
    checkOutput("t4_noSecond", 32'(busyVec[sel]), 32'd0);

    // Reset during data bit 3
    doReset(2'd0);
    applyStimulus(1'b1, 8'hC3, 1'b0);
    for (int i = 1; i < 70; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t5_tx",    32'(txVec[sel]),    32'd1);
    checkOutput("t5_ready", 32'(readyVec[sel]), 32'd1);
    checkOutput("t5_busy",  32'(busyVec[sel]),  32'd0);
    dones = 0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      if (doneVec[sel]) dones++;
    end
    checkOutput("t5_noDone", 32'(dones), 32'd0);

    // 8N2, tick every 4th cycle, accept on a tick cycle
    tickMode = 1;
    doReset(2'd3);
    while ((cyc % 4) != 0) applyStimulus(1'b0, 8'h00, 1'b0);
    probeLv[0:10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    probeCnt = 11;
    runFrame("t6", 8'h01, 704, 64, 128, -1);
    probeCnt = 0;

    // Randomised traffic on every configuration
    for (int s = 0; s < 4; s++) begin
      tickMode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      doReset(2'(s));
      for (int i = 0; i < 2500; i++)
        applyStimulus($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 1499) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
